pipeline_hazard_unit: RTL

- Parametrised hazard/forwarding controller for the next-generation pipelined MIPS datapath.
- Replaces the single-cycle datapath's implicit "PC enable on ihit & !dhit" gating with a scoreboard of in-flight register writes.
- Generates forwarding selects, load-use bubbles, memory-wait freezes, branch flushes and halt drain.
- Sits between decode, the later pipeline stages and the datapath_cache_if hit signals.

---
 rtl/pipeline_hazard_unit_if.sv | 41 ++++
 rtl/pipeline_hazard_unit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_unit_if.sv
// Decode/control bundle between the datapath and pipeline_hazard_unit.
// master = datapath side, slave = hazard unit.
interface pipeline_hazard_unit_if #(
    parameter int unsigned SEL_W = 5,
    parameter int unsigned FWD_W = 2
) ();
    logic             id_valid;
    logic [SEL_W-1:0] id_rs;
    logic [SEL_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_wen;
    logic [SEL_W-1:0] id_wsel;
    logic             id_load;
    logic             id_halt;
    logic             ex_redirect;
    logic             ihit;
    logic             dhit;
    logic             dmem_req;

    logic             pc_en;
    logic             id_hold;
    logic             ex_bubble;
    logic             id_flush;
    logic             freeze;
    logic [FWD_W-1:0] fwd_a;
    logic [FWD_W-1:0] fwd_b;
    logic             halt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wen, id_wsel, id_load,
               id_halt, ex_redirect, ihit, dhit, dmem_req,
        input  pc_en, id_hold, ex_bubble, id_flush, freeze, fwd_a, fwd_b, halt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wen, id_wsel, id_load,
               id_halt, ex_redirect, ihit, dhit, dmem_req,
        output pc_en, id_hold, ex_bubble, id_flush, freeze, fwd_a, fwd_b, halt
    );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// Scoreboard-based hazard/forwarding controller for the pipelined MIPS datapath.
// Optional saturating event counters are enabled with the HAZARD_STATS_EN macro.
module pipeline_hazard_unit #(
    parameter int unsigned REGS       = 32,
    parameter int unsigned STAGES     = 3,
    parameter int unsigned LOAD_STAGE = 1,
    parameter int unsigned SEL_W      = $clog2(REGS),
    parameter int unsigned FWD_W      = $clog2(STAGES + 1)
) (
    input logic                   CLK,
    input logic                   nRST,
    pipeline_hazard_unit_if.slave bus
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]           stat_lu,
    output logic [31:0]           stat_frz,
    output logic [31:0]           stat_flush
`endif
);

    localparam int unsigned CntW = $clog2(STAGES + 1);

    logic [STAGES-1:0]            sb_valid_q, sb_valid_d;
    logic [STAGES-1:0]            sb_load_q, sb_load_d;
    logic [STAGES-1:0][SEL_W-1:0] sb_wsel_q, sb_wsel_d;
    logic                         redirect_pend_q, redirect_pend_d;
    logic                         halt_seen_q, halt_seen_d;
    logic                         halt_q, halt_d;
    logic [CntW-1:0]              drain_q, drain_d;

    logic             hit_a, hit_b, load_a, load_b;
    logic [FWD_W-1:0] idx_a, idx_b;
    logic             lu_a, lu_b;
    logic             freeze, flush_now, load_use, enter, halt_issue;

    // Scan oldest to youngest so the youngest match wins.
    always_comb begin
        hit_a  = 1'b0;
        hit_b  = 1'b0;
        load_a = 1'b0;
        load_b = 1'b0;
        idx_a  = '0;
        idx_b  = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (sb_valid_q[k] && sb_wsel_q[k] == bus.id_rs && bus.id_rs != '0) begin
                hit_a  = 1'b1;
                load_a = sb_load_q[k];
                idx_a  = FWD_W'(k);
            end
            if (sb_valid_q[k] && sb_wsel_q[k] == bus.id_rt && bus.id_rt != '0) begin
                hit_b  = 1'b1;
                load_b = sb_load_q[k];
                idx_b  = FWD_W'(k);
            end
        end
    end

    always_comb begin
        lu_a       = bus.id_use_rs & hit_a & load_a & (idx_a < FWD_W'(LOAD_STAGE));
        lu_b       = bus.id_use_rt & hit_b & load_b & (idx_b < FWD_W'(LOAD_STAGE));
        freeze     = bus.dmem_req & ~bus.dhit;
        flush_now  = ~freeze & (bus.ex_redirect | redirect_pend_q);
        load_use   = bus.id_valid & (lu_a | lu_b) & ~freeze & ~flush_now;
        enter      = bus.id_valid & bus.id_wen & (bus.id_wsel != '0) & ~load_use & ~flush_now;
        halt_issue = bus.id_valid & bus.id_halt & ~freeze & ~load_use & ~flush_now &
                     ~halt_seen_q;

        bus.freeze    = freeze;
        bus.id_flush  = flush_now;
        bus.ex_bubble = load_use;
        bus.id_hold   = freeze | load_use;
        bus.pc_en     = bus.ihit & ~freeze & ~load_use & ~halt_seen_q;
        bus.fwd_a     = (bus.id_use_rs & hit_a & ~lu_a) ? idx_a + FWD_W'(1) : '0;
        bus.fwd_b     = (bus.id_use_rt & hit_b & ~lu_b) ? idx_b + FWD_W'(1) : '0;
        bus.halt      = halt_q;
    end

    always_comb begin
        sb_valid_d = sb_valid_q;
        sb_load_d  = sb_load_q;
        sb_wsel_d  = sb_wsel_q;
        if (!freeze) begin
            for (int k = STAGES - 1; k > 0; k--) begin
                sb_valid_d[k] = sb_valid_q[k-1];
                sb_load_d[k]  = sb_load_q[k-1];
                sb_wsel_d[k]  = sb_wsel_q[k-1];
            end
            sb_valid_d[0] = enter;
            sb_load_d[0]  = bus.id_load;
            sb_wsel_d[0]  = bus.id_wsel;
        end
    end

    // A redirect seen while frozen is replayed as a flush on the first unfrozen cycle.
    always_comb begin
        redirect_pend_d = freeze ? (redirect_pend_q | bus.ex_redirect) : 1'b0;
        halt_seen_d     = halt_seen_q | halt_issue;
        drain_d         = drain_q;
        halt_d          = halt_q;
        if (halt_seen_q && !halt_q && !freeze) begin
            drain_d = drain_q + CntW'(1);
            if (drain_q == CntW'(STAGES - 1)) begin
                halt_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            sb_valid_q      <= '0;
            sb_load_q       <= '0;
            sb_wsel_q       <= '0;
            redirect_pend_q <= 1'b0;
            halt_seen_q     <= 1'b0;
            halt_q          <= 1'b0;
            drain_q         <= '0;
        end else begin
            sb_valid_q      <= sb_valid_d;
            sb_load_q       <= sb_load_d;
            sb_wsel_q       <= sb_wsel_d;
            redirect_pend_q <= redirect_pend_d;
            halt_seen_q     <= halt_seen_d;
            halt_q          <= halt_d;
            drain_q         <= drain_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stat_lu_q, stat_lu_d;
    logic [31:0] stat_frz_q, stat_frz_d;
    logic [31:0] stat_flush_q, stat_flush_d;

    always_comb begin
        stat_lu_d    = (load_use && stat_lu_q != '1) ? stat_lu_q + 32'd1 : stat_lu_q;
        stat_frz_d   = (freeze && stat_frz_q != '1) ? stat_frz_q + 32'd1 : stat_frz_q;
        stat_flush_d = (flush_now && stat_flush_q != '1) ? stat_flush_q + 32'd1 : stat_flush_q;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            stat_lu_q    <= '0;
            stat_frz_q   <= '0;
            stat_flush_q <= '0;
        end else begin
            stat_lu_q    <= stat_lu_d;
            stat_frz_q   <= stat_frz_d;
            stat_flush_q <= stat_flush_d;
        end
    end

    assign stat_lu    = stat_lu_q;
    assign stat_frz   = stat_frz_q;
    assign stat_flush = stat_flush_q;
`endif

endmodule
